// File: rtl/bw_clk_gl_fdbk_lkdt.sv
// Feedback-clock lock detector: counts synchronized feedback-clock rising edges
// over a programmable rclk window and declares lock after consecutive passing windows.
module bw_clk_gl_fdbk_lkdt #(
  parameter int unsigned WIN_W    = 10,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned LOCK_CNT = 4
) (
  input  logic             rclk,
  input  logic             rst,
  input  logic             en,
  input  logic             clk_fdbk_in,
  input  logic [WIN_W-1:0] win_len,
  input  logic [CNT_W-1:0] exp_cnt,
  input  logic [CNT_W-1:0] tol,
  output logic             lock,
  output logic             meas_vld,
  output logic [CNT_W-1:0] meas_cnt,
  output logic             err
);

  localparam logic [CNT_W-1:0] ECNT_MAX = '1;
  localparam logic [4:0]       LOCK_TGT = 5'(LOCK_CNT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t state, state_d;

  logic             s1, s2, s3;
  logic             rise;
  logic [WIN_W-1:0] wcnt, wcnt_d, win_len_q, win_len_d;
  logic [CNT_W-1:0] ecnt, ecnt_d, exp_cnt_q, exp_cnt_d, tol_q, tol_d;
  logic [CNT_W-1:0] meas_cnt_d, fin;
  logic [3:0]       good, good_d;
  logic             lock_d, meas_vld_d, err_d;
  logic             term, pass;
  logic signed [CNT_W:0] diff;
  logic [CNT_W:0]        adiff;

  // Synchronizer plus edge-detect delay flop; runs in every state.
  always_ff @(posedge rclk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= clk_fdbk_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise  = s2 & ~s3;
  assign term  = (wcnt == (win_len_q - WIN_W'(1)));
  assign fin   = (ecnt == ECNT_MAX) ? ecnt : (ecnt + CNT_W'(rise));
  assign diff  = $signed({1'b0, fin}) - $signed({1'b0, exp_cnt_q});
  assign adiff = diff[CNT_W] ? $unsigned(-diff) : $unsigned(diff);
  assign pass  = (adiff <= {1'b0, tol_q});

  always_comb begin
    state_d    = state;
    wcnt_d     = wcnt;
    ecnt_d     = ecnt;
    good_d     = good;
    win_len_d  = win_len_q;
    exp_cnt_d  = exp_cnt_q;
    tol_d      = tol_q;
    meas_cnt_d = meas_cnt;
    meas_vld_d = 1'b0;
    err_d      = 1'b0;

    if (!en) begin
      // Disable abandons the partial window without a measurement.
      state_d = IDLE;
      wcnt_d  = '0;
      ecnt_d  = '0;
      good_d  = '0;
    end else begin
      case (state)
        IDLE: begin
          state_d   = ACQ;
          wcnt_d    = '0;
          ecnt_d    = '0;
          good_d    = '0;
          win_len_d = win_len;
          exp_cnt_d = exp_cnt;
          tol_d     = tol;
        end
        ACQ, LOCKED: begin
          if (term) begin
            wcnt_d     = '0;
            ecnt_d     = '0;
            meas_cnt_d = fin;
            meas_vld_d = 1'b1;
            win_len_d  = win_len;
            exp_cnt_d  = exp_cnt;
            tol_d      = tol;
            if (pass) begin
              if (state == ACQ) begin
                good_d = good + 4'd1;
                if ((5'(good) + 5'd1) == LOCK_TGT) state_d = LOCKED;
              end
            end else begin
              good_d  = '0;
              state_d = ACQ;
              err_d   = (state == LOCKED);
            end
          end else begin
            wcnt_d = wcnt + WIN_W'(1);
            ecnt_d = fin;
          end
        end
        default: begin
          state_d = IDLE;
          wcnt_d  = '0;
          ecnt_d  = '0;
          good_d  = '0;
        end
      endcase
    end

    lock_d = (state_d == LOCKED);
  end

  // State, counters, shadow configuration and registered outputs.
  always_ff @(posedge rclk) begin
    if (rst) begin
      state     <= IDLE;
      wcnt      <= '0;
      ecnt      <= '0;
      good      <= '0;
      win_len_q <= '0;
      exp_cnt_q <= '0;
      tol_q     <= '0;
      lock      <= 1'b0;
      meas_vld  <= 1'b0;
      meas_cnt  <= '0;
      err       <= 1'b0;
    end else begin
      state     <= state_d;
      wcnt      <= wcnt_d;
      ecnt      <= ecnt_d;
      good      <= good_d;
      win_len_q <= win_len_d;
      exp_cnt_q <= exp_cnt_d;
      tol_q     <= tol_d;
      lock      <= lock_d;
      meas_vld  <= meas_vld_d;
      meas_cnt  <= meas_cnt_d;
      err       <= err_d;
    end
  end

endmodule

// File: doc/bw_clk_gl_fdbk_lkdt.md
# bw_clk_gl_fdbk_lkdt

Feedback-clock lock detector at the receiving end of the global clock feedback path. It samples the returned feedback clock `clk_fdbk_in` in the `rclk` domain and counts its rising edges over a programmable window of `rclk` cycles. It compares each window's count against an expected value with a tolerance, and asserts `lock` after a run of consecutive passing windows. It sits beside the clock generator and drives the lock status used by clock control and reset sequencing.

## Interface
- `WIN_W`, 10: window-length counter width.
- `CNT_W`, 8: edge-counter width.
- `LOCK_CNT`, 4: consecutive passing windows required for lock (1..15).
- `rclk` in 1: the block's only clock. All state is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: enable. Low forces IDLE.
- `clk_fdbk_in` in 1: returned feedback clock, asynchronous to `rclk`. Its frequency is < `rclk`/2.
- `win_len` in WIN_W: window length in `rclk` cycles. 0 means 2^WIN_W.
- `exp_cnt` in CNT_W: expected edges per window.
- `tol` in CNT_W: allowed absolute deviation.
- `lock` out 1: locked status.
- `meas_vld` out 1: one-cycle pulse at the end of each window.
- `meas_cnt` out CNT_W: count for the last completed window. Held between pulses.
- `err` out 1: one-cycle pulse when a window fails while locked.

## Operation
- **Synchronizer:** 2-flop synchronizer on `clk_fdbk_in` (s1, s2), followed by delay flop s3. `rise` = s2 & ~s3.
- **Configuration sampling:** `win_len`, `exp_cnt` and `tol` are captured into shadow registers on IDLE->ACQ and at every window end. Changes mid-window do not affect the current window.
- **Window counter:** `wcnt` counts 0..`win_len_q`-1 and then wraps to 0. The terminal cycle is `wcnt == win_len_q - 1`, computed modulo 2^WIN_W.
- **Edge counter:** `ecnt` increments on `rise` and saturates at 2^CNT_W-1.
  - On the terminal cycle, `final = sat(ecnt + rise)` and `ecnt` clears to 0.
  - An edge on the cycle after the terminal cycle counts in the new window.
- **Pass test:** |`final` - `exp_cnt_q`| <= `tol_q`, evaluated with a CNT_W+1-bit signed difference. There is no wrap.
- **FSM states:** IDLE, ACQ, LOCKED. `good` is a 4-bit counter.
  - **IDLE:** `wcnt`, `ecnt` and `good` are held at 0 and `lock`=0. If `en`=1, go to ACQ on the next edge.
  - **ACQ, window pass:** `good`+1. If `good`+1 == `LOCK_CNT`, go to LOCKED.
  - **ACQ, window fail:** `good` <= 0. Stay in ACQ. `err` stays 0.
  - **LOCKED, window pass:** stay in LOCKED.
  - **LOCKED, window fail:** go to ACQ, `good` <= 0, `err` pulses.
  - **Any state, `en`=0:** go to IDLE on the next edge. Counters clear, `lock` drops, and no `meas_vld` is issued for the partial window.
- **Synchronizer while idle:** the synchronizer flops keep sampling in all states, so `rise` is valid immediately on entry to ACQ.
- **Reset:** `rst` overrides everything, including mid-window. State goes to IDLE and s1/s2/s3, `wcnt`, `ecnt`, `good`, `lock`, `meas_vld`, `meas_cnt` and `err` all go to 0.

## Timing
- **Reset values:** `lock`=0, `meas_vld`=0, `meas_cnt`=0, `err`=0.
- **Edge-to-count latency:** a `clk_fdbk_in` rise is counted 3 `rclk` edges later (s1, s2, s3 compare).
- **Window-end outputs:** `meas_vld`, `meas_cnt`, `err` and the updated `lock` all register on the edge that ends the terminal cycle. They are visible together in the following cycle.
- **Window period:** first window starts in the cycle after IDLE->ACQ. Windows are back-to-back with no gap, so `meas_vld` has a period of exactly `win_len_q` cycles.
- **Lock latency:** `lock` rises in the same cycle as the `LOCK_CNT`-th consecutive passing `meas_vld`.
- **Loss of lock:** `lock` falls in the same cycle as the failing `meas_vld`/`err`.
- **Disable/reset:** `lock` falls one cycle after `en`=0 or `rst`=1 is sampled.

## Test plan
- **Reset:** assert `rst` for 3 cycles with `clk_fdbk_in` toggling -> all outputs 0; with `en` still high, first `meas_vld` occurs `win_len`+1 cycles after `rst` falls.
- **Acquire lock:** `clk_fdbk_in` period 8 `rclk`, `win_len`=64, `exp_cnt`=8, `tol`=1, `LOCK_CNT`=4, `en`=1 -> `meas_cnt`=8 every 64 cycles; `lock`=1 with the 4th `meas_vld`; `err` never pulses.
- **Loss of lock:** locked as above, then stop `clk_fdbk_in` -> first full window gives `meas_cnt`=0 (or 1 if a straddling edge falls in it) -> `err` pulses once, `lock`=0 in that cycle, state ACQ; restart clock -> relock after 4 more windows.
- **Tolerance boundary:** `exp_cnt`=8, `tol`=1 -> count 9 passes; count 10 fails and clears `good`; count 7 passes; count 6 fails.
- **Saturation and wrap:** `CNT_W`=4, `clk_fdbk_in` period 4, `win_len`=0 (1024 cycles) -> `meas_cnt`=15 and no wrap to a small value; window period 1024 cycles.
- **Mid-window disable and reset:** drop `en` at `wcnt`=30 while locked -> `lock`=0 next cycle, no `meas_vld`; re-enable -> full 64-cycle window before the next `meas_vld`. Repeat with `rst` instead of `en` -> same result.
